// File: rtl/ysyx_220066_pkg.sv
// Shared types and constants for the ysyx_220066 fetch path.
package ysyx_220066_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_OUT
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_220066_fetch_sel.sv
// Instruction slot mux: picks the 32-bit half of the fetched word addressed by pc[2].
module ysyx_220066_fetch_sel #(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic              hi,
    output logic [31:0]       inst
);

    always_comb begin
        inst = hi ? rdata[63:32] : rdata[31:0];
    end

endmodule

// File: rtl/ysyx_220066_fetch_resp.sv
// Fetch responder: single-outstanding aligned imem read, slot select, valid/ready to ID.
// Optional YSYX_220066_FETCH_MISALIGN_EN: misaligned PCs return a nop flagged by inst_misalign.
module ysyx_220066_fetch_resp
    import ysyx_220066_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              block_out,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef YSYX_220066_FETCH_MISALIGN_EN
    output logic [31:0]       inst,
    output logic              inst_misalign
`else
    output logic [31:0]       inst
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              drop_pend_q, drop_pend_d;
    logic [31:0]       sel_inst;
    logic              acc;
    logic              dropping;
    logic              misalign;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
    logic              misalign_q, misalign_d;
    assign misalign = (pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    ysyx_220066_fetch_sel #(.DATA_W(DATA_W)) u_sel (
        .rdata (mem_rdata),
        .hi    (pc_q[2]),
        .inst  (sel_inst)
    );

    assign acc       = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & inst_ready));
    assign dropping  = flush | drop_pend_q;
    assign block_out = ~acc & ~flush;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_pc_d   = inst_pc_q;
        inst_d      = inst_q;
        drop_pend_d = drop_pend_q;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
        misalign_d  = misalign_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    state_d     = ST_REQ;
                    pc_d        = pc_in;
                    drop_pend_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (misalign) begin
                    state_d = dropping ? ST_IDLE : ST_OUT;
                    if (!dropping) begin
                        inst_d    = NOP_INST;
                        inst_pc_d = pc_q;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
                        misalign_d = 1'b1;
`endif
                    end
                end else begin
                    // A flush before the grant must not retract the request; remember it instead.
                    if (flush) drop_pend_d = 1'b1;
                    if (mem_gnt) begin
                        if (mem_rvalid) begin
                            state_d = dropping ? ST_IDLE : ST_OUT;
                            if (!dropping) begin
                                inst_d    = sel_inst;
                                inst_pc_d = pc_q;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
                                misalign_d = 1'b0;
`endif
                            end
                        end else begin
                            state_d = dropping ? ST_DROP : ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d = dropping ? ST_IDLE : ST_OUT;
                    if (!dropping) begin
                        inst_d    = sel_inst;
                        inst_pc_d = pc_q;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
                        misalign_d = 1'b0;
`endif
                    end
                end else if (dropping) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_rvalid) state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (inst_ready) begin
                    state_d     = ST_REQ;
                    pc_d        = pc_in;
                    drop_pend_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            inst_pc_q   <= '0;
            inst_q      <= '0;
            drop_pend_q <= 1'b0;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_pc_q   <= inst_pc_d;
            inst_q      <= inst_d;
            drop_pend_q <= drop_pend_d;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign mem_req    = (state_q == ST_REQ) & ~misalign;
    assign mem_addr   = {pc_q[ADDR_W-1:3], 3'b000};
    assign inst_valid = (state_q == ST_OUT);
    assign inst_pc    = inst_pc_q;
    assign inst       = inst_q;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
    assign inst_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_220066_fetch_resp.sv
// Randomized scoreboard bench for ysyx_220066_fetch_resp with a transaction-level fetch model.
module tb_ysyx_220066_fetch_resp;
    import ysyx_220066_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_in;
    logic        flush;
    logic        block_out;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [63:0] inst_pc;
    logic [31:0] inst;
`ifdef YSYX_220066_FETCH_MISALIGN_EN
    logic        inst_misalign;
`endif

    ysyx_220066_fetch_resp #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .flush      (flush),
        .block_out  (block_out),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_pc    (inst_pc),
`ifdef YSYX_220066_FETCH_MISALIGN_EN
        .inst       (inst),
        .inst_misalign (inst_misalign)
`else
        .inst       (inst)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int handshakes = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of the aligned address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00100093_00000013;
        return {a[31:0] * 32'd3 + 32'h0000_1111, a[31:0] ^ 32'hDEAD_0000};
    endfunction

    function automatic logic [31:0] exp_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = mem_word({pc[63:3], 3'b000});
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    // Stimulus knobs.
    int          flush_pct = 0, ready_pct = 100, gnt_pct = 100, rv_min = 2, rv_max = 2;
    bit          pc_fix = 1'b1;
    logic [63:0] pc_val = RESET_PC;
    logic        rst_next = 1'b1;
    bit          last_gnt, last_req;

    // Memory model state: at most one read in flight.
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_addr = '0;

    task automatic cycle();
        int d;
        @(negedge clk);
        rst        = rst_next;
        flush      = ($urandom_range(0, 99) < flush_pct);
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        pc_in      = pc_fix ? pc_val : RESET_PC + 64'({$urandom_range(0, 1023), 2'b00});
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
        last_req   = mem_req;
        last_gnt   = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(m_addr);
                m_busy     = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (mem_req && ($urandom_range(0, 99) < gnt_pct)) begin
            mem_gnt  = 1'b1;
            last_gnt = 1'b1;
            m_addr   = mem_addr;
            d        = $urandom_range(rv_min, rv_max);
            if (d == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(m_addr);
            end else begin
                m_busy = 1'b1;
                m_cnt  = d - 1;
            end
        end
        @(posedge clk);
    endtask

    task automatic wait_gnt(input string nm);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_gnt) return;
        end
        chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_req(input string nm);
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (last_req) return;
        end
        chk({nm, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Scoreboard: each accepted PC becomes one pending fetch until consumed or discarded.
    typedef struct {
        logic [63:0] pc;
        bit          granted;
        bit          returned;
        bit          killed;
        int          age;
    } pend_t;
    pend_t pq[$];

    initial begin : monitor
        bit has, exp_valid, exp_req, consume, exp_acc, exp_block;
        forever begin
            @(negedge clk);
            #4;
            if (rst !== 1'b1) begin
                pq.delete();
                continue;
            end
            has       = (pq.size() != 0);
            exp_valid = has && pq[0].returned && !pq[0].killed;
            exp_req   = has && !pq[0].granted;
            consume   = exp_valid && inst_ready;
            exp_acc   = !flush && (!has || consume);
            exp_block = !exp_acc && !flush;
            chk("inst_valid", 64'(inst_valid), 64'(exp_valid));
            chk("block_out", 64'(block_out), 64'(exp_block));
            chk("mem_req", 64'(mem_req), 64'(exp_req));
            if (exp_req) chk("mem_addr", mem_addr, pq[0].pc & ~64'h7);
            if (exp_valid) begin
                chk("inst", 64'(inst), 64'(exp_inst(pq[0].pc)));
                chk("inst_pc", inst_pc, pq[0].pc);
            end
`ifdef YSYX_220066_FETCH_MISALIGN_EN
            if (exp_valid) chk("inst_misalign", 64'(inst_misalign), 64'd0);
`endif
            if (consume) handshakes++;
            if (has) begin
                if (mem_gnt && exp_req) pq[0].granted = 1'b1;
                if (mem_rvalid && pq[0].granted) pq[0].returned = 1'b1;
                if (consume) begin
                    pq.delete(0);
                end else begin
                    if (flush) pq[0].killed = 1'b1;
                    if (pq[0].killed && pq[0].returned) begin
                        pq.delete(0);
                    end else begin
                        pq[0].age++;
                        if (pq[0].age > 100) begin
                            chk("fetch_progress_timeout", 64'd0, 64'd1);
                            pq.delete(0);
                        end
                    end
                end
            end
            if (exp_acc) pq.push_back('{pc: pc_in, granted: 1'b0, returned: 1'b0, killed: 1'b0, age: 0});
        end
    end

    initial begin : stimulus
        rst = 1'b1; flush = 1'b0; inst_ready = 1'b1; pc_in = RESET_PC;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        rst_next = 1'b0;
        repeat (2) cycle();
        rst_next = 1'b1;

        // Base fetch, then upper slot of the same word.
        pc_fix = 1'b1; pc_val = RESET_PC;
        repeat (8) cycle();
        pc_val = RESET_PC + 64'h4;
        repeat (8) cycle();

        // ID back-pressure.
        ready_pct = 0;
        repeat (6) cycle();
        ready_pct = 100;
        repeat (4) cycle();

        // Flush one cycle after the grant, while the read is in flight.
        pc_val = RESET_PC + 64'h40; rv_min = 4; rv_max = 4;
        wait_gnt("flush_wait");
        flush_pct = 100; pc_val = RESET_PC + 64'h100;
        cycle();
        flush_pct = 0; rv_min = 2; rv_max = 2;
        repeat (12) cycle();

        // Flush while the request is waiting for a grant.
        gnt_pct = 0; pc_val = RESET_PC + 64'h200;
        wait_req("flush_req");
        flush_pct = 100;
        cycle();
        flush_pct = 0;
        repeat (2) cycle();
        gnt_pct = 100; rv_min = 1; rv_max = 1;
        repeat (10) cycle();

        // Randomized traffic.
        pc_fix = 1'b0;
        for (int blk = 0; blk < 15; blk++) begin
            flush_pct = $urandom_range(0, 20);
            ready_pct = $urandom_range(30, 100);
            gnt_pct   = $urandom_range(30, 100);
            rv_min    = 0;
            rv_max    = $urandom_range(0, 4);
            repeat (200) cycle();
        end

        // Asynchronous reset while a read is outstanding; its late rvalid must be ignored.
        flush_pct = 0; ready_pct = 100; gnt_pct = 100; rv_min = 6; rv_max = 6;
        pc_fix = 1'b1; pc_val = RESET_PC + 64'h8;
        repeat (8) cycle();
        while (m_busy) cycle();
        wait_gnt("areset");
        cycle();
        @(negedge clk);
        #2 rst = 1'b0; rst_next = 1'b0;
        #1;
        chk("areset_mem_req", 64'(mem_req), 64'd0);
        chk("areset_mem_addr", mem_addr, 64'd0);
        chk("areset_inst_valid", 64'(inst_valid), 64'd0);
        chk("areset_inst_pc", inst_pc, 64'd0);
        chk("areset_inst", 64'(inst), 64'd0);
        flush_pct = 100;
        repeat (2) cycle();
        rst_next = 1'b1;
        repeat (10) cycle();
        flush_pct = 0; rv_min = 1; rv_max = 2;
        repeat (20) cycle();

        chk("handshakes_seen", 64'(handshakes > 20), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
